// File: rtl/lfsr_stim_gen_if.sv
// Output stream of lfsr_stim_gen: a data word qualified by valid, accepted by ready.
// A word moves on any clock edge where out_valid and out_ready are both high.
interface lfsr_stim_gen_if #(
  parameter int WIDTH = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/lfsr_stim_gen.sv
// Seeded maximal-length LFSR stimulus source delivering num_words words over valid/ready, then a done pulse.
// Define STIM_FORCE_EXTREMES_EN to prefix every run with 8'h00 and 8'hFF (counted in num_words).
module lfsr_stim_gen #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   seed,
  input  logic [COUNT_W-1:0] num_words,
  output logic               busy,
  output logic               done,
  lfsr_stim_gen_if.master    out_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   seed_fix;
  logic               xfer;

  // x^8+x^6+x^5+x^4+1, Fibonacci form; the all-zero state never recurs
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] d);
    return {d[WIDTH-2:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
  endfunction

  assign seed_fix = (seed == '0) ? WIDTH'(1) : seed;
  assign xfer     = (state_q == RUN) && out_if.out_ready;

`ifdef STIM_FORCE_EXTREMES_EN
  // high while the leading 8'h00 is on the bus; lfsr_q then still holds the seed
  logic zero_ph_q, zero_ph_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_ph_q <= 1'b0;
    else     zero_ph_q <= zero_ph_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      lfsr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      lfsr_q  <= lfsr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    lfsr_d  = lfsr_q;
`ifdef STIM_FORCE_EXTREMES_EN
    zero_ph_d = zero_ph_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = num_words;
          if (num_words == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
`ifdef STIM_FORCE_EXTREMES_EN
            data_d    = '0;
            lfsr_d    = seed_fix;
            zero_ph_d = 1'b1;
`else
            data_d    = seed_fix;
            lfsr_d    = lfsr_step(seed_fix);
`endif
          end
        end
      end
      RUN: begin
        if (xfer) begin
          cnt_d = cnt_q - COUNT_W'(1);
          if (cnt_q == COUNT_W'(1)) begin
            // last word stays on out_data after the run
            state_d = DONE;
          end else begin
`ifdef STIM_FORCE_EXTREMES_EN
            zero_ph_d = 1'b0;
            if (zero_ph_q) begin
              data_d = '1;
            end else begin
              data_d = lfsr_q;
              lfsr_d = lfsr_step(lfsr_q);
            end
`else
            data_d = lfsr_q;
            lfsr_d = lfsr_step(lfsr_q);
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_if.out_valid = (state_q == RUN);
  assign out_if.out_data  = data_q;
  assign busy             = (state_q == RUN);
  assign done             = (state_q == DONE);

endmodule

// File: tb/tb_lfsr_stim_gen.sv
// Randomized bench for lfsr_stim_gen: a word-list model predicts every output each cycle,
// plus literal word sequences from the directed scenarios.
module tb_lfsr_stim_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [7:0] num_words = 8'h00;
  logic       busy, done;

  lfsr_stim_gen_if #(.WIDTH(8)) sif ();

  lfsr_stim_gen #(.WIDTH(8), .COUNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed      (seed),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .out_if    (sif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  function automatic logic [7:0] step(input logic [7:0] d);
    return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
  endfunction

  // Reference: the full word list of a run, computed up front from seed and count.
  function automatic void build_words(input logic [7:0] s, input int n, output logic [7:0] w[$]);
    logic [7:0] x;
    int k;
    w.delete();
    x = (s == 8'h00) ? 8'h01 : s;
    k = 0;
`ifdef STIM_FORCE_EXTREMES_EN
    if (n >= 1) begin w.push_back(8'h00); k++; end
    if (n >= 2) begin w.push_back(8'hFF); k++; end
`endif
    while (k < n) begin
      w.push_back(x);
      x = step(x);
      k++;
    end
  endfunction

  bit         m_active, m_done;
  logic [7:0] m_last;
  logic [7:0] m_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0;
      m_done   = 0;
      m_last   = 8'h00;
      m_q.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (sif.out_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_active = 0;
          m_done   = 1;
        end else begin
          m_last = m_q[0];
        end
      end
    end else if (start) begin
      build_words(seed, int'(num_words), m_q);
      if (m_q.size() == 0) m_done = 1;
      else begin
        m_active = 1;
        m_last   = m_q[0];
      end
    end
  end

  logic [7:0] log_q[$];
  int         done_cnt;

  always @(negedge clk) begin
    chk("valid", {31'd0, sif.out_valid}, {31'd0, m_active});
    chk("busy",  {31'd0, busy},          {31'd0, m_active});
    chk("done",  {31'd0, done},          {31'd0, m_done});
    chk("data",  {24'd0, sif.out_data},  {24'd0, m_last});
    if (!rst && sif.out_valid && sif.out_ready) log_q.push_back(sif.out_data);
    if (done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int pct, input bit start_noise, input int limit);
    int n = 0;
    while ((m_active || m_done) && n < limit) begin
      sif.out_ready = ($urandom_range(99) < pct);
      if (start_noise) start = ($urandom_range(2) == 0);
      cyc();
      n++;
    end
    start = 1'b0;
    if (m_active || m_done) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic run(input logic [7:0] s, input logic [7:0] n, input int pct, input bit noise);
    log_q.delete();
    done_cnt      = 0;
    seed          = s;
    num_words     = n;
    start         = 1'b1;
    sif.out_ready = ($urandom_range(99) < pct);
    cyc();
    start     = 1'b0;
    seed      = 8'($urandom);
    num_words = 8'($urandom);
    wait_idle(pct, noise, 3000);
  endtask

  task automatic check_log(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, log_q.size(), exp.size());
    foreach (exp[i]) if (i < log_q.size()) chk(name, {24'd0, log_q[i]}, {24'd0, exp[i]});
  endtask

  logic [7:0] e[$];
  logic [7:0] x;

  initial begin
    sif.out_ready = 1'b0;
    x = 8'h01;
    for (int i = 0; i < 5; i++) x = step(x);
    chk("model_pin", {24'd0, x}, 32'h23);

    repeat (2) cyc();
    chk("rst_data", {24'd0, sif.out_data}, 32'h00);
    rst = 1'b0;
    cyc();

`ifdef STIM_FORCE_EXTREMES_EN
    e = '{8'h00, 8'hFF, 8'h01, 8'h02, 8'h04, 8'h08};
`else
    e = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
`endif
    run(8'h01, 8'd6, 100, 0);
    check_log("basic", e);
    chk("basic_done", done_cnt, 1);

`ifdef STIM_FORCE_EXTREMES_EN
    e = '{8'h00, 8'hFF};
`else
    e = '{8'h01, 8'h02};
`endif
    run(8'h00, 8'd2, 100, 0);
    check_log("zero_seed", e);

    // backpressure on the second word
    log_q.delete();
    seed = 8'h01; num_words = 8'd3; start = 1'b1; sif.out_ready = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    sif.out_ready = 1'b0;
    repeat (3) begin
      cyc();
`ifdef STIM_FORCE_EXTREMES_EN
      chk("bp_hold", {24'd0, sif.out_data}, 32'hFF);
`else
      chk("bp_hold", {24'd0, sif.out_data}, 32'h02);
`endif
      chk("bp_valid", {31'd0, sif.out_valid}, 32'd1);
    end
    wait_idle(100, 0, 100);
`ifdef STIM_FORCE_EXTREMES_EN
    e = '{8'h00, 8'hFF, 8'h01};
`else
    e = '{8'h01, 8'h02, 8'h04};
`endif
    check_log("bp", e);

    run(8'h5A, 8'd0, 100, 0);
    chk("zero_cnt_words", log_q.size(), 0);
    chk("zero_cnt_done", done_cnt, 1);

    run(8'h3C, 8'd5, 70, 1);
    chk("start_noise_words", log_q.size(), 5);
    chk("start_noise_done", done_cnt, 1);

    // reset after two of six transfers, asserted between clock edges
    seed = 8'h01; num_words = 8'd6; start = 1'b1; sif.out_ready = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, sif.out_valid}, 32'd0);
    chk("arst_busy",  {31'd0, busy},          32'd0);
    chk("arst_done",  {31'd0, done},          32'd0);
    chk("arst_data",  {24'd0, sif.out_data},  32'h00);
    cyc();
    #2 rst = 1'b0;
    cyc();
`ifdef STIM_FORCE_EXTREMES_EN
    e = '{8'h00, 8'hFF, 8'h80, 8'h01};
`else
    e = '{8'h80, 8'h01, 8'h02, 8'h04};
`endif
    run(8'h80, 8'd4, 100, 0);
    check_log("replay", e);

    run(8'hC3, 8'd255, 100, 0);
    chk("max_words", log_q.size(), 255);
    chk("max_done", done_cnt, 1);

    for (int r = 0; r < 25; r++) begin
      logic [7:0] n;
      n = 8'($urandom_range(0, 40));
      run(8'($urandom), n, int'($urandom_range(30, 100)), ($urandom_range(3) == 0));
      chk("rand_len", log_q.size(), {24'd0, n});
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_stim_gen.md
# lfsr_stim_gen

Pseudo-random 8-bit stimulus source for the unary-operator test stage. It replaces free-running `$random()` with a seeded, reproducible, maximal-length LFSR sequence. It delivers an exact number of words over a valid/ready handshake and signals completion. It sits directly upstream of the unary reduction (NAND/NOR/AND-of-NOT/OR-of-NOT) stage and drives its `a` input.

## Interface
- `WIDTH`, 8: data width; the LFSR polynomial is defined for 8 only.
- `COUNT_W`, 8: width of the word-count request and internal counter.
- `clk`  in  1  system clock; all registers update on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `seed`  in  8  initial LFSR value, captured on accepted `start`.
- `num_words`  in  COUNT_W  number of words to deliver, captured on accepted `start`.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  8  stimulus word.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the last transfer.

## Operation
- States:
  - IDLE: waits for `start`. Then goes to RUN, or goes directly to DONE when `num_words == 0`.
  - RUN: sends words until the remaining count reaches zero, then goes to DONE.
  - DONE: lasts exactly 1 cycle, then returns to IDLE.
- LFSR: Fibonacci, polynomial x^8+x^6+x^5+x^4+1, period 255.
  - `fb = d[7]^d[5]^d[4]^d[3]`
  - `next = {d[6:0], fb}`
- Seed 8'h00 is a lock-up state. It is replaced by 8'h01 on capture.
- Transfer occurs when `out_valid && out_ready`.
  - On a transfer, the LFSR advances and the remaining count decrements.
  - Without a transfer, `out_data` and `out_valid` hold stable. There is no retraction.
- `out_ready` may be high at any time. It is ignored while `out_valid` is low.
- `start` is ignored in RUN and DONE. A `start` in the DONE cycle is lost.
- `seed` and `num_words` may change freely after capture.
- Count arithmetic:
  - The counter is unsigned COUNT_W bits.
  - `num_words = 2^COUNT_W-1` is the maximum run.
  - Runs longer than 255 words wrap the LFSR sequence naturally.

## Timing
- Reset values:
  - `out_valid`, `busy`, `done` = 0.
  - `out_data` = 8'h00.
  - State = IDLE.
  - Counter = 0.
- Reset asserted mid-run aborts at once. Outputs take their reset values asynchronously, and no `done` pulse is produced.
- `start` accepted at edge N:
  - From edge N: `busy` and `out_valid` = 1, and `out_data` = first word.
  - Each further transfer at edge k presents the next word from edge k. The steady-state rate is 1 word per cycle.
- Last transfer at edge M:
  - From edge M: `out_valid` and `busy` = 0, and `done` = 1.
  - From edge M+1: `done` = 0 and the state is IDLE.
  - `out_data` keeps its last value.
- `num_words == 0`: `done` pulses for the cycle after `start` is accepted, and `out_valid` never rises.

## Configuration
- `STIM_FORCE_EXTREMES_EN`: defined means the first two words of every run are 8'h00 then 8'hFF, followed by the LFSR sequence from the seed.
  - The LFSR never emits 00, so this covers the all-zero and all-one corner cases of the downstream reductions.
  - The extremes count toward `num_words`.
  - With `num_words == 1`, only 8'h00 is sent.
- Undefined means the LFSR sequence starts directly with the (substituted) seed.

## Test plan
- Basic run (macro off):
  - Stimulus: seed 8'h01, `num_words` 6, `out_ready` held 1.
  - Required: words 01, 02, 04, 08, 11, 23 on consecutive cycles, then a `done` pulse 1 cycle later, `out_valid` low.
- Zero seed:
  - Stimulus: seed 8'h00, `num_words` 2.
  - Required: words 01, 02.
- Backpressure:
  - Stimulus: seed 8'h01, `num_words` 3, `out_ready` low for 3 cycles at the second word.
  - Required: `out_data` holds 02 with `out_valid`=1 throughout, then 04 follows; exactly 3 transfers.
- Zero count:
  - Stimulus: `num_words` 0.
  - Required: no `out_valid`; `done` high for exactly 1 cycle; `start` pulses during RUN are ignored.
- Reset mid-run:
  - Stimulus: `rst` asserted after 2 of 6 words.
  - Required: `out_valid`/`busy`/`done` drop without waiting for a clock edge. A fresh `start` replays from the new seed.
- Extremes (macro on):
  - Stimulus: seed 8'h01, `num_words` 4.
  - Required: words 00, FF, 01, 02.
